// File: rtl/bus_xfer_if.sv
// Command handshake bundle for bus_xfer_ctrl: one valid/ready transfer command in,
// done/err completion pulses out.
interface bus_xfer_if #(
  parameter int DW = 4,
  parameter int AW = 4
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [1:0]    cmd_src;
  logic [1:0]    cmd_dst;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic          done;
  logic          err;

  modport master (
    output cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_addr, cmd_data,
    input  cmd_ready, done, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_addr, cmd_data,
    output cmd_ready, done, err
  );
endinterface

// File: rtl/bus_xfer_ctrl.sv
// Shared-bus transfer sequencer: three registers plus a 16-entry RAM, one command per handshake.
// Optional SWAP (op 10) is built only when BUS_XFER_SWAP_EN is defined.
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// READ   | bus latch loads the source value (or immediate)
// READ2  | SWAP only: tmp loads the destination value
// WRITE  | destination loads the bus latch
// WRITE2 | SWAP only: source loads tmp
// DONE   | done (and err for illegal op) high for one cycle
module bus_xfer_ctrl #(
  parameter int DW = 4,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  bus_xfer_if.slave     cmd,
  input  logic [AW-1:0] view_addr,
  output logic [DW-1:0] bus_q,
  output logic [DW-1:0] r0,
  output logic [DW-1:0] r1,
  output logic [DW-1:0] r2,
  output logic [DW-1:0] ram_view
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_READ   = 3'd1;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd5;
`ifdef BUS_XFER_SWAP_EN
  localparam logic [2:0] S_READ2  = 3'd2;
  localparam logic [2:0] S_WRITE2 = 3'd4;
`endif

  localparam logic [1:0] OP_MOVE = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_SWAP = 2'b10;
  localparam logic [1:0] SEL_RAM = 2'd3;

  logic [2:0]    state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [1:0]    src_q, src_d;
  logic [1:0]    dst_q, dst_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic [DW-1:0] bus_lat_q, bus_lat_d;
  logic [DW-1:0] r0_q, r0_d;
  logic [DW-1:0] r1_q, r1_d;
  logic [DW-1:0] r2_q, r2_d;
`ifdef BUS_XFER_SWAP_EN
  logic [DW-1:0] tmp_q, tmp_d;
`endif

  logic [DW-1:0] mem [2**AW];
  logic          mem_we;
  logic [DW-1:0] mem_wdata;

  logic          wr_en;
  logic [1:0]    wr_sel;
  logic [DW-1:0] wr_val;
  logic          op_legal;
  logic          is_swap;
  logic [DW-1:0] src_val;
  logic [DW-1:0] dst_val;

  function automatic logic [DW-1:0] sel_val(input logic [1:0] sel,
                                             input logic [DW-1:0] v0,
                                             input logic [DW-1:0] v1,
                                             input logic [DW-1:0] v2,
                                             input logic [DW-1:0] vm);
    logic [DW-1:0] v;
    case (sel)
      2'd0:    v = v0;
      2'd1:    v = v1;
      2'd2:    v = v2;
      default: v = vm;
    endcase
    return v;
  endfunction

  always_comb begin
    src_val = sel_val(src_q, r0_q, r1_q, r2_q, mem[addr_q]);
    dst_val = sel_val(dst_q, r0_q, r1_q, r2_q, mem[addr_q]);
  end

`ifdef BUS_XFER_SWAP_EN
  assign is_swap  = (op_q == OP_SWAP);
  assign op_legal = (op_q == OP_MOVE) || (op_q == OP_LOAD) || (op_q == OP_SWAP);
`else
  assign is_swap  = 1'b0;
  assign op_legal = (op_q == OP_MOVE) || (op_q == OP_LOAD);
`endif

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    src_d     = src_q;
    dst_d     = dst_q;
    addr_d    = addr_q;
    data_d    = data_q;
    bus_lat_d = bus_lat_q;
`ifdef BUS_XFER_SWAP_EN
    tmp_d     = tmp_q;
`endif
    wr_en     = 1'b0;
    wr_sel    = dst_q;
    wr_val    = bus_lat_q;

    case (state_q)
      S_IDLE: begin
        if (cmd.cmd_valid) begin
          op_d    = cmd.cmd_op;
          src_d   = cmd.cmd_src;
          dst_d   = cmd.cmd_dst;
          addr_d  = cmd.cmd_addr;
          data_d  = cmd.cmd_data;
          state_d = S_READ;
        end
      end
      S_READ: begin
        bus_lat_d = (op_q == OP_LOAD) ? data_q : src_val;
`ifdef BUS_XFER_SWAP_EN
        state_d   = is_swap ? S_READ2 : S_WRITE;
`else
        state_d   = S_WRITE;
`endif
      end
`ifdef BUS_XFER_SWAP_EN
      S_READ2: begin
        tmp_d   = dst_val;
        state_d = S_WRITE;
      end
`endif
      S_WRITE: begin
        wr_en   = op_legal;
        wr_sel  = dst_q;
        wr_val  = bus_lat_q;
`ifdef BUS_XFER_SWAP_EN
        state_d = is_swap ? S_WRITE2 : S_DONE;
`else
        state_d = S_DONE;
`endif
      end
`ifdef BUS_XFER_SWAP_EN
      S_WRITE2: begin
        wr_en   = 1'b1;
        wr_sel  = src_q;
        wr_val  = tmp_q;
        state_d = S_DONE;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Write port shared by WRITE (to dst) and WRITE2 (back to src).
  always_comb begin
    r0_d      = r0_q;
    r1_d      = r1_q;
    r2_d      = r2_q;
    mem_we    = 1'b0;
    mem_wdata = wr_val;
    if (wr_en) begin
      case (wr_sel)
        2'd0:    r0_d   = wr_val;
        2'd1:    r1_d   = wr_val;
        2'd2:    r2_d   = wr_val;
        default: mem_we = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= OP_MOVE;
      src_q     <= 2'd0;
      dst_q     <= 2'd0;
      addr_q    <= '0;
      data_q    <= '0;
      bus_lat_q <= '0;
      r0_q      <= '0;
      r1_q      <= '0;
      r2_q      <= '0;
`ifdef BUS_XFER_SWAP_EN
      tmp_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      bus_lat_q <= bus_lat_d;
      r0_q      <= r0_d;
      r1_q      <= r1_d;
      r2_q      <= r2_d;
`ifdef BUS_XFER_SWAP_EN
      tmp_q     <= tmp_d;
`endif
    end
  end

  // RAM contents survive reset; a reset before the WRITE edge simply suppresses the write.
  always_ff @(posedge clk) begin
    if (mem_we && rst_n) begin
      mem[addr_q] <= mem_wdata;
    end
  end

  assign cmd.cmd_ready = (state_q == S_IDLE);
  assign cmd.done      = (state_q == S_DONE);
  assign cmd.err       = (state_q == S_DONE) && !op_legal;

  assign bus_q    = bus_lat_q;
  assign r0       = r0_q;
  assign r1       = r1_q;
  assign r2       = r2_q;
  assign ram_view = mem[view_addr];

  logic unused_sel_ram;
  assign unused_sel_ram = (SEL_RAM == 2'd3);

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Self-checking bench for bus_xfer_ctrl: constant vector table, multi-cycle corner sequences,
// then random commands against a register/RAM array model. Honours BUS_XFER_SWAP_EN.
module tb_bus_xfer_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] view_addr = '0;
  logic [3:0] bus_q, r0, r1, r2, ram_view;
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;

`ifdef BUS_XFER_SWAP_EN
  localparam bit SWAP_EN = 1'b1;
`else
  localparam bit SWAP_EN = 1'b0;
`endif

  bus_xfer_if #(.DW(4), .AW(4)) bif ();

  bus_xfer_ctrl #(.DW(4), .AW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd       (bif.slave),
    .view_addr (view_addr),
    .bus_q     (bus_q),
    .r0        (r0),
    .r1        (r1),
    .r2        (r2),
    .ram_view  (ram_view)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference model: architectural state only.
  logic [3:0] m_r [3];
  logic [3:0] m_ram [16];
  logic [3:0] m_bus;

  function automatic logic [3:0] m_get(input logic [1:0] sel, input logic [3:0] a);
    return (sel == 2'd3) ? m_ram[a] : m_r[sel];
  endfunction

  task automatic m_put(input logic [1:0] sel, input logic [3:0] a, input logic [3:0] v);
    if (sel == 2'd3) m_ram[a] = v;
    else             m_r[sel] = v;
  endtask

  // Returns the expected err flag.
  task automatic m_apply(input logic [1:0] op, input logic [1:0] src, input logic [1:0] dst,
                         input logic [3:0] a, input logic [3:0] d, output bit e);
    logic [3:0] vs, vd;
    vs = m_get(src, a);
    vd = m_get(dst, a);
    e  = 1'b0;
    if (op == 2'b01) begin
      m_bus = d;
      m_put(dst, a, d);
    end else if (op == 2'b00) begin
      m_bus = vs;
      m_put(dst, a, vs);
    end else if (op == 2'b10 && SWAP_EN) begin
      m_bus = vs;
      m_put(dst, a, vs);
      m_put(src, a, vd);
    end else begin
      m_bus = vs;
      e     = 1'b1;
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 3; i++) m_r[i] = '0;
    m_bus = '0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [1:0] src, input logic [1:0] dst,
                       input logic [3:0] a, input logic [3:0] d);
    bif.cmd_op   = op;
    bif.cmd_src  = src;
    bif.cmd_dst  = dst;
    bif.cmd_addr = a;
    bif.cmd_data = d;
  endtask

  task automatic chk_state(input string nm, input logic [3:0] a);
    view_addr = a;
    #1;
    chk({nm, "_r0"},  r0,       m_r[0]);
    chk({nm, "_r1"},  r1,       m_r[1]);
    chk({nm, "_r2"},  r2,       m_r[2]);
    chk({nm, "_bus"}, bus_q,    m_bus);
    chk({nm, "_ram"}, ram_view, m_ram[a]);
  endtask

  // Full command: handshake, latency, pulse width, err, then model state compare.
  task automatic do_cmd(input string nm, input logic [1:0] op, input logic [1:0] src,
                        input logic [1:0] dst, input logic [3:0] a, input logic [3:0] d,
                        input bit full);
    int k;
    bit e, seen;
    int exp_k;
    @(negedge clk);
    drive(op, src, dst, a, d);
    bif.cmd_valid = 1'b1;
    k = 0;
    while (!bif.cmd_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!bif.cmd_ready) chk({nm, "_accept_timeout"}, 0, 1);
    @(posedge clk);
    #1;
    bif.cmd_valid = 1'b0;
    drive(2'($urandom), 2'($urandom), 2'($urandom), 4'($urandom), 4'($urandom));
    m_apply(op, src, dst, a, d, e);
    exp_k = (op == 2'b10 && SWAP_EN) ? 5 : 3;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 12) begin
      @(negedge clk);
      k++;
      if (bif.done) seen = 1'b1;
      else if (full && bif.cmd_ready) chk({nm, "_ready_busy"}, 1, 0);
    end
    if (full) chk({nm, "_latency"}, k, exp_k);
    else if (!seen) chk({nm, "_done_timeout"}, 0, 1);
    chk({nm, "_err"}, bif.err, e);
    @(negedge clk);
    if (full) begin
      chk({nm, "_done_one"}, bif.done, 0);
      chk({nm, "_ready_back"}, bif.cmd_ready, 1);
    end
    chk_state(nm, a);
  endtask

  typedef struct {
    logic [1:0] op, src, dst;
    logic [3:0] addr, data;
    logic [3:0] e_r0, e_r1, e_r2, e_bus, e_ram;
    logic       e_err;
  } vec_t;

  vec_t tbl [9];

  initial begin : main
    int acc [2];
    int nacc;
    bit e;
    bif.cmd_valid = 1'b0;
    drive(2'd0, 2'd0, 2'd0, 4'd0, 4'd0);
    m_reset();

    // Vector table (RAM preloaded with ~addr, registers start at zero).
    tbl[0] = '{2'b01, 2'd2, 2'd0, 4'd0, 4'h5, 4'h5, 4'h0, 4'h0, 4'h5, 4'hF, 1'b0};
    tbl[1] = '{2'b00, 2'd0, 2'd3, 4'd3, 4'h0, 4'h5, 4'h0, 4'h0, 4'h5, 4'h5, 1'b0};
    tbl[2] = '{2'b00, 2'd3, 2'd2, 4'd3, 4'h0, 4'h5, 4'h0, 4'h5, 4'h5, 4'h5, 1'b0};
    tbl[3] = '{2'b01, 2'd3, 2'd1, 4'd7, 4'hA, 4'h5, 4'hA, 4'h5, 4'hA, 4'h8, 1'b0};
    tbl[4] = '{2'b00, 2'd1, 2'd1, 4'd0, 4'h0, 4'h5, 4'hA, 4'h5, 4'hA, 4'hF, 1'b0};
    tbl[5] = '{2'b00, 2'd3, 2'd3, 4'd9, 4'h0, 4'h5, 4'hA, 4'h5, 4'h6, 4'h6, 1'b0};
    tbl[6] = '{2'b11, 2'd1, 2'd0, 4'd2, 4'h3, 4'h5, 4'hA, 4'h5, 4'hA, 4'hD, 1'b1};
`ifdef BUS_XFER_SWAP_EN
    tbl[7] = '{2'b10, 2'd0, 2'd1, 4'd0, 4'h0, 4'hA, 4'h5, 4'h5, 4'h5, 4'hF, 1'b0};
    tbl[8] = '{2'b01, 2'd0, 2'd3, 4'd4, 4'hC, 4'hA, 4'h5, 4'h5, 4'hC, 4'hC, 1'b0};
`else
    tbl[7] = '{2'b10, 2'd0, 2'd1, 4'd0, 4'h0, 4'h5, 4'hA, 4'h5, 4'h5, 4'hF, 1'b1};
    tbl[8] = '{2'b01, 2'd0, 2'd3, 4'd4, 4'hC, 4'h5, 4'hA, 4'h5, 4'hC, 4'hC, 1'b0};
`endif

    // Reset values.
    #12;
    chk("rst_r0", r0, 0);
    chk("rst_r1", r1, 0);
    chk("rst_r2", r2, 0);
    chk("rst_bus", bus_q, 0);
    chk("rst_ready", bif.cmd_ready, 1);
    chk("rst_done", bif.done, 0);
    chk("rst_err", bif.err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Preload RAM via LOAD-to-RAM, then restore register model (LOAD does not touch regs).
    for (int a = 0; a < 16; a++) do_cmd("init", 2'b01, 2'd0, 2'd3, 4'(a), ~4'(a), 1'b0);

    for (int i = 0; i < 9; i++) begin
      do_cmd($sformatf("vec%0d", i), tbl[i].op, tbl[i].src, tbl[i].dst, tbl[i].addr,
             tbl[i].data, 1'b1);
      view_addr = tbl[i].addr;
      #1;
      chk($sformatf("tbl%0d_r0", i), r0, tbl[i].e_r0);
      chk($sformatf("tbl%0d_r1", i), r1, tbl[i].e_r1);
      chk($sformatf("tbl%0d_r2", i), r2, tbl[i].e_r2);
      chk($sformatf("tbl%0d_bus", i), bus_q, tbl[i].e_bus);
      chk($sformatf("tbl%0d_ram", i), ram_view, tbl[i].e_ram);
    end

    // Back-to-back with cmd_valid held: fields changed while busy must be ignored.
    @(negedge clk);
    drive(2'b01, 2'd0, 2'd2, 4'd0, 4'h7);
    bif.cmd_valid = 1'b1;
    nacc = 0;
    acc[0] = 0;
    acc[1] = 0;
    for (int i = 0; i < 16 && nacc < 2; i++) begin
      if (bif.cmd_valid && bif.cmd_ready) begin
        acc[nacc] = cyc;
        nacc++;
      end
      @(negedge clk);
      if (nacc == 1) drive(2'b01, 2'd0, 2'd0, 4'd0, 4'h9);
      if (nacc == 2) begin
        bif.cmd_valid = 1'b0;
        drive(2'b01, 2'd0, 2'd1, 4'd0, 4'hF);
      end
    end
    chk("b2b_count", nacc, 2);
    chk("b2b_spacing", acc[1] - acc[0], 4);
    m_apply(2'b01, 2'd0, 2'd2, 4'd0, 4'h7, e);
    m_apply(2'b01, 2'd0, 2'd0, 4'd0, 4'h9, e);
    repeat (6) @(negedge clk);
    chk("b2b_r2", r2, 4'h7);
    chk("b2b_r0", r0, 4'h9);
    chk_state("b2b", 4'd0);

    // Async reset while in WRITE: register write is lost, no done.
    @(negedge clk);
    drive(2'b01, 2'd0, 2'd1, 4'd0, 4'h3);
    bif.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bif.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_reset();
    chk("midrst_ready", bif.cmd_ready, 1);
    chk("midrst_done", bif.done, 0);
    chk_state("midrst", 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("midrst_r1_lost", r1, 0);
    chk("midrst_no_done", bif.done, 0);

`ifdef BUS_XFER_SWAP_EN
    // Reset between WRITE and WRITE2: only the destination (RAM) keeps the new value.
    do_cmd("sw_pre", 2'b01, 2'd0, 2'd0, 4'd5, 4'h6, 1'b1);
    @(negedge clk);
    drive(2'b10, 2'd0, 2'd3, 4'd5, 4'h0);
    bif.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bif.cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_reset();
    m_ram[5] = 4'h6;
    chk_state("swrst", 4'd5);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    // Random commands against the model.
    for (int i = 0; i < 120; i++) begin
      do_cmd("rnd", 2'($urandom), 2'($urandom), 2'($urandom), 4'($urandom), 4'($urandom),
             1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
